sdspi_arbiter: RTL and testbench
================================

# sdspi_arbiter

Shares one `sdspihost` instance between two requesters, e.g. an autotest feed reader and a result writer. It owns host bring-up: holds the host in reset, then waits for card init to finish. It then grants the SPI command port to one requester at a time, round-robin, and latches host errors. It sits between the autotest FSMs and `sdspihost`, in place of a direct FSM-to-host connection.

## Interface
- `RST_CYCLES`, 16: cycles `spi_reset` is held high after `rst`.
- `TIMEOUT`, 2**24: max cycles `spi_busy` may stay high in `INIT_WAIT`/`RELEASE` before error.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-low.
- `req` in [1:0]: per-requester access request, level.
- `gnt` out [1:0]: one-hot-or-zero grant, registered.
- `ready` out 1: host initialised, arbiter accepting requests.
- `err` out 1: sticky error (host `err` or timeout).
- `r_block_i`, `r_multi_block_i`, `r_byte_i`, `w_block_i`, `w_byte_i` in [1:0]: per-requester commands.
- `block_addr_i` in [63:0]: requester n at [32n+31:32n].
- `data_in_i` in [15:0]: requester n at [8n+7:8n].
- `busy_o` out [1:0]: per-requester busy view.
- `data_out_o` out [7:0]: host `data_out` broadcast.
- `spi_reset`, `spi_r_block`, `spi_r_multi_block`, `spi_r_byte`, `spi_w_block`, `spi_w_byte` out 1 each: to host.
- `spi_block_addr` out [31:0]: to host.
- `spi_data_in` out [7:0]: to host.
- `spi_busy`, `spi_err` in 1 each: from host.
- `spi_data_out` in [7:0]: from host.

## Operation
- States: `INIT_RST`, `INIT_WAIT`, `IDLE`, `GRANT`, `RELEASE`, `ERROR`.
- `INIT_RST`: `spi_reset`=1; an internal counter counts `RST_CYCLES`, then the FSM moves to `INIT_WAIT`.
- `INIT_WAIT`: `spi_reset`=0; on `spi_busy`=0 go to `IDLE`, with `ready`=1 from then on.
- `IDLE`:
  - Single `req` bit set: grant it.
  - Both set: grant the requester not equal to `last`.
  - `last` resets to 1, so requester 0 wins the first tie.
  - On grant: `gnt` one-hot, `last`<=granted index, go to `GRANT`.
- `GRANT`:
  - Host command/addr/data inputs driven combinationally from the granted requester only. The other requester's commands are masked to 0.
  - When the granted `req` falls, `gnt`<=0 and go to `RELEASE`.
- `RELEASE`: wait `spi_busy`=0, then `IDLE`. Minimum one cycle in `RELEASE`.
- Busy view:
  - `busy_o[n]` = `spi_busy` when `gnt[n]`, else 1.
  - `busy_o` is all ones outside `GRANT`.
- `spi_err`=1 in any state past `INIT_RST`: go to `ERROR`, `err`<=1, `gnt`<=0, `ready`<=0.
- Timeout counter: runs in `INIT_WAIT` and `RELEASE` while `spi_busy`=1. Reaching `TIMEOUT`-1 leads to `ERROR`. The counter is cleared on state entry.
- `ERROR`: all host commands 0, terminal until `rst`=0.
- `rst`=0 mid-transaction: everything returns to reset values on the next edge, including `spi_reset`=1. The in-flight host operation is abandoned.

## Timing
- Reset values: `gnt`=0, `ready`=0, `err`=0, `spi_reset`=1, all `spi_*` commands 0, `spi_block_addr`=0, `spi_data_in`=0, `busy_o`=2'b11, `last`=1, state `INIT_RST`.
- Grant latency: `req` sampled high in `IDLE` at edge k gives `gnt` high after edge k. Earliest command forwarding is in cycle k+1.
- Release: `req` low at edge k gives `gnt` low after edge k. Commands asserted in the same cycle that `req` falls are still forwarded.
- Requester rules: hold `req` until its last command completes (`busy_o` low), then drop `req`. Re-request no earlier than the cycle after `gnt` falls.
- Same-cycle `spi_err` and `req` fall: error wins.
- `req` rising in `RELEASE` is held pending until `IDLE`.
- `data_out_o` is combinational passthrough, zero latency.

## Structure
- Shared package `sdspi_arb_pkg`: state enum `arb_state_t`, `NUM_REQ`=2, `ADDR_W`=32, `DATA_W`=8.
- One sub-module: `sdspi_cmd_mux`, purely combinational, selecting requester commands by grant index with masking. The FSM, counters and `last` stay in the top.

## Test plan
- Reset release with `RST_CYCLES`=16 and a host model busy for 100 cycles after reset: `spi_reset` high exactly 16 cycles, `ready` rises 1 cycle after `spi_busy` falls, `gnt`=0 throughout.
- `req`=2'b01, `r_block_i[0]`=1 pulse, addr 0x0000_0200: `gnt`=01 next cycle, `spi_block_addr`=0x200, `spi_r_block` pulse forwarded, `busy_o[1]`=1.
- `req`=2'b11 held in `IDLE` after reset: grants go 0,1,0,1 across four request/release cycles.
- Requester 1 asserts `w_byte_i[1]`, `data_in_i`=0xA5xx while `gnt`=01: `spi_w_byte`=0, `spi_data_in` tracks requester 0.
- `spi_err` pulses during `GRANT`: next cycle `err`=1, `gnt`=0, `ready`=0. The arbiter stays there until `rst`=0, then re-enters `INIT_RST`.
- `TIMEOUT`=64 with `spi_busy` stuck high after release: `err`=1 exactly 64 cycles after `RELEASE` entry.

Source files
------------

// File: rtl/sdspi_arbiter_pkg.sv
// Purpose: shared types and sizes for the two-requester SD-SPI host arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sdspi_arb_pkg;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 8;

  typedef enum logic [2:0] {
    INIT_RST  = 3'd0,
    INIT_WAIT = 3'd1,
    IDLE      = 3'd2,
    GRANT     = 3'd3,
    RELEASE   = 3'd4,
    ERROR     = 3'd5
  } arb_state_t;

  // One requester's (or the host's) command strobes, bundled.
  typedef struct packed {
    logic r_block;
    logic r_multi_block;
    logic r_byte;
    logic w_block;
    logic w_byte;
  } cmd_t;

endpackage

// File: rtl/sdspi_arbiter_if.sv
// Purpose: command/status port of one sdspihost instance.
// Latency: wires only.
// Backpressure: host reports spi_busy; master must not issue while busy.
// Ports: master = arbiter side (drives reset/commands/addr/data),
//        slave  = host side (drives busy/err/data_out).
interface sdspi_arbiter_if;
  import sdspi_arb_pkg::*;

  logic              spi_reset;
  logic              spi_r_block;
  logic              spi_r_multi_block;
  logic              spi_r_byte;
  logic              spi_w_block;
  logic              spi_w_byte;
  logic [ADDR_W-1:0] spi_block_addr;
  logic [DATA_W-1:0] spi_data_in;
  logic              spi_busy;
  logic              spi_err;
  logic [DATA_W-1:0] spi_data_out;

  modport master (
    output spi_reset, spi_r_block, spi_r_multi_block, spi_r_byte,
           spi_w_block, spi_w_byte, spi_block_addr, spi_data_in,
    input  spi_busy, spi_err, spi_data_out
  );

  modport slave (
    input  spi_reset, spi_r_block, spi_r_multi_block, spi_r_byte,
           spi_w_block, spi_w_byte, spi_block_addr, spi_data_in,
    output spi_busy, spi_err, spi_data_out
  );

endinterface

// File: rtl/sdspi_arbiter_cmd_mux.sv
// Purpose: picks one requester's command/addr/data for the host, zeroes the rest.
// Latency: combinational, zero cycles.
// Backpressure: none; when i_en is low everything to the host is 0.
// Ports: i_en/i_sel select, i_* per-requester buses, o_cmd/o_addr/o_data to host.
module sdspi_cmd_mux
  import sdspi_arb_pkg::*;
(
  input  logic                      i_en,
  input  logic                      i_sel,
  input  logic [NUM_REQ-1:0]        i_r_block,
  input  logic [NUM_REQ-1:0]        i_r_multi_block,
  input  logic [NUM_REQ-1:0]        i_r_byte,
  input  logic [NUM_REQ-1:0]        i_w_block,
  input  logic [NUM_REQ-1:0]        i_w_byte,
  input  logic [NUM_REQ*ADDR_W-1:0] i_block_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_data_in,
  output cmd_t                      o_cmd,
  output logic [ADDR_W-1:0]         o_addr,
  output logic [DATA_W-1:0]         o_data
);

  always_comb begin
    o_cmd  = '0;
    o_addr = '0;
    o_data = '0;
    if (i_en) begin
      o_cmd.r_block       = i_r_block[i_sel];
      o_cmd.r_multi_block = i_r_multi_block[i_sel];
      o_cmd.r_byte        = i_r_byte[i_sel];
      o_cmd.w_block       = i_w_block[i_sel];
      o_cmd.w_byte        = i_w_byte[i_sel];
      o_addr = i_sel ? i_block_addr[2*ADDR_W-1:ADDR_W] : i_block_addr[ADDR_W-1:0];
      o_data = i_sel ? i_data_in[2*DATA_W-1:DATA_W]    : i_data_in[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/sdspi_arbiter.sv
// Purpose: brings up one sdspihost and shares its command port round-robin between two requesters.
// Latency: grant one cycle after req sampled in IDLE; commands forwarded combinationally while granted.
// Backpressure: host spi_busy is reflected to the granted requester on busy_o; others see busy=1.
// Ports: clk/rst (sync, active-low); req/gnt/ready/err arbitration; per-requester command buses;
//        busy_o/data_out_o status back to requesters; host = master side of the host port.
module sdspi_arbiter
  import sdspi_arb_pkg::*;
#(
  parameter int RST_CYCLES = 16,
  parameter int TIMEOUT    = 2**24
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      ready,
  output logic                      err,
  input  logic [NUM_REQ-1:0]        r_block_i,
  input  logic [NUM_REQ-1:0]        r_multi_block_i,
  input  logic [NUM_REQ-1:0]        r_byte_i,
  input  logic [NUM_REQ-1:0]        w_block_i,
  input  logic [NUM_REQ-1:0]        w_byte_i,
  input  logic [NUM_REQ*ADDR_W-1:0] block_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] data_in_i,
  output logic [NUM_REQ-1:0]        busy_o,
  output logic [DATA_W-1:0]         data_out_o,
  sdspi_arbiter_if.master           host
);

  // One counter serves both the reset hold and the busy timeout; it is
  // cleared on every state change so each use starts from zero.
  localparam int CNT_MAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

  arb_state_t         r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_gnt,   w_gnt_nxt;
  logic               r_last,  w_last_nxt;   // index of most recent grant
  logic [CNT_W-1:0]   r_cnt,   w_cnt_nxt;
  logic               w_pick;
  cmd_t               w_cmd;
  logic [ADDR_W-1:0]  w_addr;
  logic [DATA_W-1:0]  w_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= INIT_RST;
      r_gnt   <= '0;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    // On a tie the requester that did not go last wins.
    w_pick      = (req == 2'b11) ? ~r_last : req[1];

    case (r_state)
      INIT_RST: begin
        if (r_cnt == RST_LAST) begin
          w_state_nxt = INIT_WAIT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      INIT_WAIT: begin
        if (!host.spi_busy) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == TO_LAST) begin
          w_state_nxt = ERROR;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      IDLE: begin
        if (req != '0) begin
          w_gnt_nxt   = w_pick ? 2'b10 : 2'b01;
          w_last_nxt  = w_pick;
          w_state_nxt = GRANT;
          w_cnt_nxt   = '0;
        end
      end

      GRANT: begin
        // r_last holds the index of the current grant.
        if (!req[r_last]) begin
          w_gnt_nxt   = '0;
          w_state_nxt = RELEASE;
          w_cnt_nxt   = '0;
        end
      end

      RELEASE: begin
        if (!host.spi_busy) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == TO_LAST) begin
          w_state_nxt = ERROR;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      ERROR: begin
        w_gnt_nxt = '0;
      end

      default: begin
        w_state_nxt = INIT_RST;
        w_gnt_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase

    // Host error overrides everything once the host is out of reset,
    // including a requester dropping req in the same cycle.
    if (r_state != INIT_RST && host.spi_err) begin
      w_state_nxt = ERROR;
      w_gnt_nxt   = '0;
      w_cnt_nxt   = '0;
    end
  end

  sdspi_cmd_mux u_cmd_mux (
    .i_en            (r_state == GRANT),
    .i_sel           (r_last),
    .i_r_block       (r_block_i),
    .i_r_multi_block (r_multi_block_i),
    .i_r_byte        (r_byte_i),
    .i_w_block       (w_block_i),
    .i_w_byte        (w_byte_i),
    .i_block_addr    (block_addr_i),
    .i_data_in       (data_in_i),
    .o_cmd           (w_cmd),
    .o_addr          (w_addr),
    .o_data          (w_data)
  );

  assign host.spi_reset         = (r_state == INIT_RST);
  assign host.spi_r_block       = w_cmd.r_block;
  assign host.spi_r_multi_block = w_cmd.r_multi_block;
  assign host.spi_r_byte        = w_cmd.r_byte;
  assign host.spi_w_block       = w_cmd.w_block;
  assign host.spi_w_byte        = w_cmd.w_byte;
  assign host.spi_block_addr    = w_addr;
  assign host.spi_data_in       = w_data;

  assign gnt        = r_gnt;
  assign ready      = (r_state == IDLE) || (r_state == GRANT) || (r_state == RELEASE);
  assign err        = (r_state == ERROR);
  assign data_out_o = host.spi_data_out;
  // r_gnt is only non-zero in GRANT, so this is all ones elsewhere.
  assign busy_o[0]  = r_gnt[0] ? host.spi_busy : 1'b1;
  assign busy_o[1]  = r_gnt[1] ? host.spi_busy : 1'b1;

endmodule

// File: tb/tb_sdspi_arbiter.sv
// Purpose: directed self-checking bench for sdspi_arbiter (bring-up, grants, masking, error, timeout).
// Latency: n/a.
// Backpressure: host model raises spi_busy for 3 cycles per command, 100 cycles after host reset.
module tb_sdspi_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rst_to = 1'b0;
  logic [1:0]  req = '0;
  logic [1:0]  r_block_i = '0, r_multi_block_i = '0, r_byte_i = '0, w_block_i = '0, w_byte_i = '0;
  logic [63:0] block_addr_i = '0;
  logic [15:0] data_in_i = '0;
  logic [1:0]  gnt, busy_o, to_gnt, to_busy_o;
  logic        ready, err, to_ready, to_err;
  logic [7:0]  data_out_o, to_data_out;

  logic        host_err = 1'b0;
  logic [7:0]  host_dout = '0;
  int          hb_cnt = 0;
  logic        to_busy = 1'b0;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  sdspi_arbiter_if host_if ();
  sdspi_arbiter_if to_if ();

  sdspi_arbiter #(.RST_CYCLES(16), .TIMEOUT(1024)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .ready(ready), .err(err),
    .r_block_i(r_block_i), .r_multi_block_i(r_multi_block_i), .r_byte_i(r_byte_i),
    .w_block_i(w_block_i), .w_byte_i(w_byte_i), .block_addr_i(block_addr_i),
    .data_in_i(data_in_i), .busy_o(busy_o), .data_out_o(data_out_o), .host(host_if)
  );

  sdspi_arbiter #(.RST_CYCLES(16), .TIMEOUT(64)) dut_to (
    .clk(clk), .rst(rst_to), .req(req), .gnt(to_gnt), .ready(to_ready), .err(to_err),
    .r_block_i(r_block_i), .r_multi_block_i(r_multi_block_i), .r_byte_i(r_byte_i),
    .w_block_i(w_block_i), .w_byte_i(w_byte_i), .block_addr_i(block_addr_i),
    .data_in_i(data_in_i), .busy_o(to_busy_o), .data_out_o(to_data_out), .host(to_if)
  );

  // Host model: busy 100 cycles after leaving reset, 3 cycles per command.
  always @(posedge clk) begin
    if (host_if.spi_reset)
      hb_cnt <= 100;
    else if (hb_cnt != 0)
      hb_cnt <= hb_cnt - 1;
    else if (host_if.spi_r_block | host_if.spi_r_multi_block | host_if.spi_r_byte |
             host_if.spi_w_block | host_if.spi_w_byte)
      hb_cnt <= 3;
  end

  assign host_if.spi_busy     = (hb_cnt != 0);
  assign host_if.spi_err      = host_err;
  assign host_if.spi_data_out = host_dout;
  assign to_if.spi_busy       = to_busy;
  assign to_if.spi_err        = 1'b0;
  assign to_if.spi_data_out   = 8'h00;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [1:0] rr_exp [4];
  logic       gnt_seen;

  initial begin
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;

    // ---- reset state
    repeat (3) @(negedge clk);
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_ready", ready, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_spi_reset", host_if.spi_reset, 1'b1);
    chk("rst_busy_o", busy_o, 2'b11);
    chk("rst_addr", host_if.spi_block_addr, 32'h0);
    chk("rst_data_in", host_if.spi_data_in, 8'h0);

    // ---- bring-up: spi_reset held 16 cycles, ready one cycle after busy falls
    rst = 1'b1;
    gnt_seen = 1'b0;
    n = 0;
    while (host_if.spi_reset && n < 200) begin
      n++;
      if (gnt != 2'b00) gnt_seen = 1'b1;
      @(negedge clk);
    end
    chk("spi_reset_cycles", n, 16);
    n = 0;
    while (host_if.spi_busy && n < 300) begin
      if (gnt != 2'b00 || ready) gnt_seen = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("init_busy_cycles", n, 100);
    chk("ready_before", ready, 1'b0);
    @(negedge clk);
    chk("ready_after", ready, 1'b1);
    chk("init_no_gnt", gnt_seen, 1'b0);

    // ---- round robin under a held tie, re-request made during RELEASE
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_gnt", gnt, rr_exp[i]);
      req = 2'b00;
      @(negedge clk);
      chk("rr_release", gnt, 2'b00);
      req = (i < 3) ? 2'b11 : 2'b00;
      @(negedge clk);
      chk("rr_pending", gnt, 2'b00);
    end

    // ---- single request, forwarding and masking of requester 1
    req = 2'b01;
    @(negedge clk);
    chk("single_gnt", gnt, 2'b01);
    chk("single_busy_o", busy_o, 2'b10);
    r_block_i    = 2'b01;
    block_addr_i = {32'hDEAD_BEEF, 32'h0000_0200};
    w_byte_i     = 2'b10;
    data_in_i    = 16'hA53C;
    host_dout    = 8'h5A;
    #1;
    chk("fwd_r_block", host_if.spi_r_block, 1'b1);
    chk("fwd_addr", host_if.spi_block_addr, 32'h0000_0200);
    chk("mask_w_byte", host_if.spi_w_byte, 1'b0);
    chk("mask_data_in", host_if.spi_data_in, 8'h3C);
    chk("data_out", data_out_o, 8'h5A);
    @(negedge clk);
    r_block_i = 2'b00;
    w_byte_i  = 2'b00;
    #1;
    chk("pulse_end", host_if.spi_r_block, 1'b0);
    chk("busy_view", busy_o, 2'b11);
    n = 0;
    while (busy_o[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_busy_cycles", n, 3);
    req = 2'b00;
    @(negedge clk);
    chk("single_release", gnt, 2'b00);
    chk("release_busy_o", busy_o, 2'b11);
    @(negedge clk);
    chk("back_idle_ready", ready, 1'b1);

    // ---- host error wins over simultaneous req fall
    req = 2'b10;
    @(negedge clk);
    chk("err_pre_gnt", gnt, 2'b10);
    req      = 2'b00;
    host_err = 1'b1;
    @(negedge clk);
    host_err = 1'b0;
    chk("err_set", err, 1'b1);
    chk("err_gnt", gnt, 2'b00);
    chk("err_ready", ready, 1'b0);
    r_block_i = 2'b11;
    req       = 2'b01;
    #1;
    chk("err_cmd_masked", host_if.spi_r_block, 1'b0);
    repeat (3) @(negedge clk);
    chk("err_sticky", err, 1'b1);
    chk("err_sticky_gnt", gnt, 2'b00);
    rst = 1'b0;
    req = 2'b00;
    @(negedge clk);
    chk("rerst_err", err, 1'b0);
    chk("rerst_spi_reset", host_if.spi_reset, 1'b1);
    chk("rerst_busy_o", busy_o, 2'b11);
    chk("rerst_cmd", host_if.spi_r_block, 1'b0);
    r_block_i = 2'b00;

    // ---- timeout: second instance with TIMEOUT=64, busy stuck after release
    rst_to = 1'b1;
    n = 0;
    while (!to_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("to_ready", to_ready, 1'b1);
    req = 2'b01;
    @(negedge clk);
    chk("to_gnt", to_gnt, 2'b01);
    to_busy = 1'b1;
    req     = 2'b00;
    @(negedge clk);
    chk("to_release", to_gnt, 2'b00);
    n = 0;
    while (!to_err && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycles", n, 64);
    chk("to_ready_low", to_ready, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
